perceptron_decision_filter: RTL and testbench

//  Downstream of the perceptron neuron. Consumes its per-cycle signed state and firing bit over a fixed window of
//  2**WIN_LOG2 accepted samples. Produces one filtered decision per window: the signed window sum plus a count of

---
 rtl/perceptron_decision_filter_pkg.sv | 20 ++
 rtl/perceptron_decision_filter_if.sv | 31 +++
 rtl/perceptron_decision_filter.sv | 180 ++++++++++++++++++
 tb/tb_perceptron_decision_filter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/perceptron_decision_filter_pkg.sv
// Shared definitions for the perceptron decision filter: default widths, accumulator
// width derivation and the window FSM state type.
package perceptron_decision_filter_pkg;

    localparam int STATE_W_DEF  = 32'sd8;
    localparam int WIN_LOG2_DEF = 32'sd3;
    localparam int HYST_DEF     = 32'sd4;

    // Exact window sum: each doubling of the window needs one extra bit.
    function automatic int acc_width(input int state_w, input int win_log2);
        return state_w + win_log2;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } pdf_state_e;

endpackage

// File: rtl/perceptron_decision_filter_if.sv
// Sample stream from the neuron and decision handshake towards the readout mux.
// master = producer/consumer side, slave = the filter.
interface perceptron_decision_filter_if
    import perceptron_decision_filter_pkg::*;
#(
    parameter int STATE_W  = STATE_W_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF
);
    localparam int ACC_W = acc_width(STATE_W, WIN_LOG2);

    logic                in_valid;
    logic [STATE_W-1:0]  state_in;
    logic                fire_in;
    logic                dec_ready;
    logic                dec_valid;
    logic                decision;
    logic [ACC_W-1:0]    win_sum;
    logic [WIN_LOG2:0]   fire_cnt;
    logic                overrun;

    modport master (
        output in_valid, state_in, fire_in, dec_ready,
        input  dec_valid, decision, win_sum, fire_cnt, overrun
    );

    modport slave (
        input  in_valid, state_in, fire_in, dec_ready,
        output dec_valid, decision, win_sum, fire_cnt, overrun
    );

endinterface

// File: rtl/perceptron_decision_filter.sv
// Windowed sum/fire-count filter over 2**WIN_LOG2 neuron samples with a valid/ready result.
// Optional feature macro: PDF_HYST_EN (hysteresis band of +/-HYST on the decision).
module perceptron_decision_filter
    import perceptron_decision_filter_pkg::*;
#(
    parameter int STATE_W  = STATE_W_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF,
    parameter int HYST     = HYST_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic cont,
    perceptron_decision_filter_if.slave bus
);

    localparam int ACC_W = acc_width(STATE_W, WIN_LOG2);

    // Without hysteresis the band collapses to nothing: sum > 0 -> 1, sum < 1 -> 0.
`ifdef PDF_HYST_EN
    localparam int TH_HI = HYST;
    localparam int TH_LO = -HYST;
`else
    localparam int TH_HI = 32'sd0 * HYST;
    localparam int TH_LO = 32'sd1;
`endif
    localparam logic signed [ACC_W-1:0] TH_HI_A  = ACC_W'(TH_HI);
    localparam logic signed [ACC_W-1:0] TH_LO_A  = ACC_W'(TH_LO);
    localparam logic [WIN_LOG2-1:0]     CNT_LAST = {WIN_LOG2{1'b1}};

    pdf_state_e               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  win_sum_q, win_sum_d;
    logic signed [ACC_W-1:0]  sample_s, sum_s;
    logic [WIN_LOG2:0]        fcnt_q, fcnt_d, fcnt_sum_s;
    logic [WIN_LOG2:0]        fire_cnt_q, fire_cnt_d;
    logic [WIN_LOG2-1:0]      cnt_q, cnt_d;
    logic                     dec_valid_q, dec_valid_d;
    logic                     decision_q, decision_d, decision_next_s;
    logic                     overrun_q, overrun_d;

    assign sample_s   = {{WIN_LOG2{bus.state_in[STATE_W-1]}}, bus.state_in};
    assign sum_s      = acc_q + sample_s;
    assign fcnt_sum_s = fcnt_q + {{WIN_LOG2{1'b0}}, bus.fire_in};

    // Decision for the window that closes with the current sample.
    always_comb begin
        decision_next_s = decision_q;
        if (sum_s > TH_HI_A) begin
            decision_next_s = 1'b1;
        end else if (sum_s < TH_LO_A) begin
            decision_next_s = 1'b0;
        end else begin
            decision_next_s = decision_q;
        end
    end

    // Window FSM: next state, accumulator and result registers.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fcnt_d      = fcnt_q;
        cnt_d       = cnt_q;
        win_sum_d   = win_sum_q;
        fire_cnt_d  = fire_cnt_q;
        decision_d  = decision_q;
        dec_valid_d = dec_valid_q;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACCUM;
                    acc_d     = '0;
                    fcnt_d    = '0;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            ACCUM: begin
                if (start) begin
                    acc_d     = '0;
                    fcnt_d    = '0;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end else if (bus.in_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d     = DONE;
                        win_sum_d   = sum_s;
                        fire_cnt_d  = fcnt_sum_s;
                        decision_d  = decision_next_s;
                        dec_valid_d = 1'b1;
                        acc_d       = '0;
                        fcnt_d      = '0;
                        cnt_d       = '0;
                    end else begin
                        acc_d  = sum_s;
                        fcnt_d = fcnt_sum_s;
                        cnt_d  = cnt_q + {{(WIN_LOG2-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ACCUM;
                end
            end

            DONE: begin
                // start outranks both the handshake and an incoming sample.
                if (start) begin
                    state_d     = ACCUM;
                    acc_d       = '0;
                    fcnt_d      = '0;
                    cnt_d       = '0;
                    overrun_d   = 1'b0;
                    dec_valid_d = 1'b0;
                end else if (dec_valid_q && bus.dec_ready) begin
                    dec_valid_d = 1'b0;
                    acc_d       = '0;
                    fcnt_d      = '0;
                    cnt_d       = '0;
                    if (cont) begin
                        state_d = ACCUM;
                        if (bus.in_valid) begin
                            acc_d  = sample_s;
                            fcnt_d = {{WIN_LOG2{1'b0}}, bus.fire_in};
                            cnt_d  = {{(WIN_LOG2-1){1'b0}}, 1'b1};
                        end else begin
                            cnt_d = '0;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.in_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d     = IDLE;
                dec_valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            fcnt_q      <= '0;
            cnt_q       <= '0;
            win_sum_q   <= '0;
            fire_cnt_q  <= '0;
            decision_q  <= 1'b0;
            dec_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fcnt_q      <= fcnt_d;
            cnt_q       <= cnt_d;
            win_sum_q   <= win_sum_d;
            fire_cnt_q  <= fire_cnt_d;
            decision_q  <= decision_d;
            dec_valid_q <= dec_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.dec_valid = dec_valid_q;
    assign bus.decision  = decision_q;
    assign bus.win_sum   = win_sum_q;
    assign bus.fire_cnt  = fire_cnt_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_perceptron_decision_filter.sv
// Directed bench for perceptron_decision_filter (default build, no hysteresis).
module tb_perceptron_decision_filter;
    import perceptron_decision_filter_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic cont;
    int   total = 0;
    int   bad   = 0;

    perceptron_decision_filter_if #(.STATE_W(8), .WIN_LOG2(3)) bus ();

    perceptron_decision_filter #(.STATE_W(8), .WIN_LOG2(3), .HYST(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .cont    (cont),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int v, input logic f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.state_in = v[7:0];
            bus.fire_in  = f;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.fire_in  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        cont          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.state_in  = 8'd0;
        bus.fire_in   = 1'b0;
        bus.dec_ready = 1'b0;
        tick();
        tick();
        chk("rst_dec_valid", bus.dec_valid, 0);
        chk("rst_win_sum", $signed(bus.win_sum), 0);
        chk("rst_fire_cnt", bus.fire_cnt, 0);
        chk("rst_decision", bus.decision, 0);
        chk("rst_overrun", bus.overrun, 0);
        reset_n = 1'b1;
        tick();

        // 1: eight +3 firing samples, single shot
        pulse_start();
        sample(3, 1'b1, 7);
        chk("t1_not_yet_valid", bus.dec_valid, 0);
        sample(3, 1'b1, 1);
        chk("t1_dec_valid", bus.dec_valid, 1);
        chk("t1_win_sum", $signed(bus.win_sum), 24);
        chk("t1_fire_cnt", bus.fire_cnt, 8);
        chk("t1_decision", bus.decision, 1);
        bus.dec_ready = 1'b1;
        sample(40, 1'b1, 1);
        bus.dec_ready = 1'b0;
        chk("t1_hs_dec_valid", bus.dec_valid, 0);
        chk("t1_hs_no_overrun", bus.overrun, 0);
        sample(1, 1'b1, 8);
        chk("t1_idle_ignores", bus.dec_valid, 0);
        chk("t1_idle_sum_held", $signed(bus.win_sum), 24);

        // 2: balanced window sums to zero
        pulse_start();
        sample(5, 1'b1, 4);
        sample(-5, 1'b0, 4);
        chk("t2_dec_valid", bus.dec_valid, 1);
        chk("t2_win_sum", $signed(bus.win_sum), 0);
        chk("t2_fire_cnt", bus.fire_cnt, 4);
        chk("t2_decision", bus.decision, 0);
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;

        // 3: most negative input, no wrap
        pulse_start();
        sample(-128, 1'b0, 8);
        chk("t3_win_sum", $signed(bus.win_sum), -1024);
        chk("t3_decision", bus.decision, 0);
        chk("t3_fire_cnt", bus.fire_cnt, 0);

        // 4: pending result, two dropped samples over five cycles
        tick();
        sample(100, 1'b1, 1);
        tick();
        sample(100, 1'b1, 1);
        tick();
        chk("t4_overrun", bus.overrun, 1);
        chk("t4_dec_valid_held", bus.dec_valid, 1);
        chk("t4_win_sum_held", $signed(bus.win_sum), -1024);
        chk("t4_fire_cnt_held", bus.fire_cnt, 0);
        pulse_start();
        chk("t4_start_clr_overrun", bus.overrun, 0);
        chk("t4_start_drop_valid", bus.dec_valid, 0);
        chk("t4_sum_kept", $signed(bus.win_sum), -1024);

        // 5: continuous mode, sample on the handshake cycle starts the next window
        cont = 1'b1;
        sample(2, 1'b1, 8);
        chk("t5_first_sum", $signed(bus.win_sum), 16);
        chk("t5_first_valid", bus.dec_valid, 1);
        bus.dec_ready = 1'b1;
        sample(7, 1'b1, 1);
        bus.dec_ready = 1'b0;
        chk("t5_hs_dec_valid", bus.dec_valid, 0);
        chk("t5_hs_no_overrun", bus.overrun, 0);
        sample(1, 1'b1, 6);
        chk("t5_not_yet_valid", bus.dec_valid, 0);
        sample(1, 1'b1, 1);
        chk("t5_dec_valid", bus.dec_valid, 1);
        chk("t5_win_sum", $signed(bus.win_sum), 14);
        chk("t5_fire_cnt", bus.fire_cnt, 8);
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
        cont = 1'b0;

        // 6: asynchronous reset mid-window, away from the clock edge
        sample(9, 1'b1, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_dec_valid", bus.dec_valid, 0);
        chk("t6_win_sum", $signed(bus.win_sum), 0);
        chk("t6_fire_cnt", bus.fire_cnt, 0);
        chk("t6_decision", bus.decision, 0);
        chk("t6_overrun", bus.overrun, 0);
        tick();
        tick();
        reset_n = 1'b1;
        sample(1, 1'b1, 8);
        chk("t6_idle_after_rst", bus.dec_valid, 0);

        // start outranks a simultaneous sample
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.state_in = 8'd50;
        bus.fire_in  = 1'b1;
        tick();
        start        = 1'b0;
        bus.in_valid = 1'b0;
        sample(1, 1'b1, 7);
        chk("t7_start_drops_sample", bus.dec_valid, 0);
        sample(1, 1'b1, 1);
        chk("t7_dec_valid", bus.dec_valid, 1);
        chk("t7_win_sum", $signed(bus.win_sum), 8);
        chk("t7_decision", bus.decision, 1);

        // start outranks a handshake: stays accumulating instead of going idle
        start         = 1'b1;
        bus.dec_ready = 1'b1;
        tick();
        start         = 1'b0;
        bus.dec_ready = 1'b0;
        chk("t8_dec_valid", bus.dec_valid, 0);
        sample(-1, 1'b0, 8);
        chk("t8_valid_again", bus.dec_valid, 1);
        chk("t8_win_sum", $signed(bus.win_sum), -8);
        chk("t8_decision", bus.decision, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
